// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder sequencing one full-adder cell, LSB first.
// Optional two's-complement overflow output enabled by defining SERIAL_ADDER_OVF_EN.

module full_adder (
    input  logic x,
    input  logic y,
    input  logic c_i,
    output logic sum,
    output logic c_o
);
    assign sum = x ^ y ^ c_i;
    assign c_o = (x & y) | (c_i & (x ^ y));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             C_OUT
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             OVF
`endif
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               c_out_q, c_out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic               fa_sum_s, fa_co_s;

    full_adder u_fa (
        .x   (a_sr_q[0]),
        .y   (b_sr_q[0]),
        .c_i (carry_q),
        .sum (fa_sum_s),
        .c_o (fa_co_s)
    );

    // Next-state and datapath; BUSY/DONE are decoded from the next state so they register glitch-free.
    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    a_sr_d  = A;
                    b_sr_d  = B;
                    carry_d = C_IN;
                    cnt_d   = {CNT_W{1'b0}};
                    sum_d   = {WIDTH{1'b0}};
                    c_out_d = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = ST_SHIFT;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                sum_d   = {fa_sum_s, sum_q[WIDTH-1:1]};
                a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
                carry_d = fa_co_s;
                cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                // On the MSB edge the carry flop still holds the carry into the MSB.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    c_out_d = fa_co_s;
                    ovf_d   = carry_q ^ fa_co_s;
                    state_d = ST_FINISH;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_SHIFT;
                    busy_d  = 1'b1;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            a_sr_q  <= {WIDTH{1'b0}};
            b_sr_q  <= {WIDTH{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign BUSY  = busy_q;
    assign DONE  = done_q;
    assign SUM   = sum_q;
    assign C_OUT = c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign OVF   = ovf_q;
`else
    logic unused_ovf_s;
    assign unused_ovf_s = ovf_q;
`endif
endmodule
